// File: rtl/bcd_clock_counter_if.sv
// Control and display bundle between the tick/set/load sources and the BCD clock core.
// Optional alarm signals exist only when BCD_CLOCK_ALARM_EN is defined.
interface bcd_clock_counter_if #(
    parameter int unsigned DAY_W = 8
);
    logic             cnt_en;
    logic             mode_12h;
    logic [1:0]       set_sel;
    logic             set_inc;
    logic             set_dec;
    logic             load;
    logic [23:0]      load_time;
    logic             load_err;
    logic [3:0]       bcd_H1, bcd_H2, bcd_M1, bcd_M2, bcd_S1, bcd_S2;
    logic             pm;
    logic             day_tick;
    logic [DAY_W-1:0] day_cnt;
`ifdef BCD_CLOCK_ALARM_EN
    logic             alarm_wr;
    logic [15:0]      alarm_time;
    logic             alarm_en;
    logic             alarm_hit;

    modport master (
        output cnt_en, mode_12h, set_sel, set_inc, set_dec, load, load_time,
               alarm_wr, alarm_time, alarm_en,
        input  load_err, bcd_H1, bcd_H2, bcd_M1, bcd_M2, bcd_S1, bcd_S2,
               pm, day_tick, day_cnt, alarm_hit
    );
    modport slave (
        input  cnt_en, mode_12h, set_sel, set_inc, set_dec, load, load_time,
               alarm_wr, alarm_time, alarm_en,
        output load_err, bcd_H1, bcd_H2, bcd_M1, bcd_M2, bcd_S1, bcd_S2,
               pm, day_tick, day_cnt, alarm_hit
    );
`else
    modport master (
        output cnt_en, mode_12h, set_sel, set_inc, set_dec, load, load_time,
        input  load_err, bcd_H1, bcd_H2, bcd_M1, bcd_M2, bcd_S1, bcd_S2,
               pm, day_tick, day_cnt
    );
    modport slave (
        input  cnt_en, mode_12h, set_sel, set_inc, set_dec, load, load_time,
        output load_err, bcd_H1, bcd_H2, bcd_M1, bcd_M2, bcd_S1, bcd_S2,
               pm, day_tick, day_cnt
    );
`endif
endinterface

// File: rtl/bcd_clock_counter.sv
// HH:MM:SS BCD time-of-day counter with prescaled tick, field set, checked load, day counter.
// Time updates one cycle after the sampling edge; no backpressure. Alarm under BCD_CLOCK_ALARM_EN.
// Digits and pm are combinational from the 24 h registers and mode_12h.
module bcd_clock_counter #(
    parameter int unsigned PRESCALE = 1,
    parameter int unsigned DAY_W    = 8
) (
    input logic               clk,
    input logic               rst,
    bcd_clock_counter_if.slave bus
);
    logic [7:0]       hr_q, mn_q, sc_q, hr_d, mn_d, sc_d;
    logic [15:0]      pre_q, pre_d;
    logic [DAY_W-1:0] day_q, day_d;
    logic             day_tick_q, day_tick_d;
    logic             load_err_q, load_err_d;
    logic [7:0]       hr_t, mn_t, sc_t;
    logic             ld_ok, set_go, pre_last, day_roll;
    logic [7:0]       disp_hr;
    logic [6:0]       hr_bin;
    logic             pm_o;
`ifdef BCD_CLOCK_ALARM_EN
    logic [15:0]      alarm_q;
    logic             alarm_hit_q, alarm_hit_d;
`endif

    function automatic logic [6:0] bcd2bin(input logic [7:0] b);
        return 7'(b[7:4]) * 7'd10 + 7'(b[3:0]);
    endfunction

    function automatic logic [7:0] bin2bcd(input logic [6:0] v);
        return {4'(v / 7'd10), 4'(v % 7'd10)};
    endfunction

    function automatic logic [7:0] bcd_inc(input logic [7:0] b);
        return (b[3:0] == 4'd9) ? {b[7:4] + 4'd1, 4'd0} : {b[7:4], b[3:0] + 4'd1};
    endfunction

    // Modular step of one field in isolation; never carries into neighbours.
    function automatic logic [7:0] field_step(input logic [7:0] b, input logic [6:0] modulus,
                                              input logic up);
        logic [6:0] v;
        v = bcd2bin(b);
        if (up) v = (v == modulus - 7'd1) ? 7'd0 : v + 7'd1;
        else    v = (v == 7'd0) ? modulus - 7'd1 : v - 7'd1;
        return bin2bcd(v);
    endfunction

    always_comb begin
        ld_ok = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (bus.load_time[i*4 +: 4] > 4'd9) ld_ok = 1'b0;
        end
        if (bus.load_time[7:4] > 4'd5 || bus.load_time[15:12] > 4'd5) ld_ok = 1'b0;
        if (bus.load_time[23:20] > 4'd2 ||
            (bus.load_time[23:20] == 4'd2 && bus.load_time[19:16] > 4'd3)) ld_ok = 1'b0;
    end

    assign set_go   = (bus.set_sel != 2'd0) && (bus.set_inc ^ bus.set_dec);
    assign pre_last = (pre_q == 16'(PRESCALE - 1));
    assign day_roll = (hr_q == 8'h23) && (mn_q == 8'h59) && (sc_q == 8'h59);

    // Ripple carry S -> M -> H, evaluated only when the prescaler wraps.
    always_comb begin
        sc_t = (sc_q == 8'h59) ? 8'h00 : bcd_inc(sc_q);
        mn_t = mn_q;
        hr_t = hr_q;
        if (sc_q == 8'h59) begin
            mn_t = (mn_q == 8'h59) ? 8'h00 : bcd_inc(mn_q);
            if (mn_q == 8'h59) hr_t = (hr_q == 8'h23) ? 8'h00 : bcd_inc(hr_q);
        end
    end

    always_comb begin
        hr_d       = hr_q;
        mn_d       = mn_q;
        sc_d       = sc_q;
        pre_d      = pre_q;
        day_d      = day_q;
        day_tick_d = 1'b0;
        load_err_d = 1'b0;
`ifdef BCD_CLOCK_ALARM_EN
        alarm_hit_d = 1'b0;
`endif
        if (bus.load) begin
            if (ld_ok) begin
                {hr_d, mn_d, sc_d} = bus.load_time;
                pre_d              = '0;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (set_go) begin
            case (bus.set_sel)
                2'd1: begin
                    sc_d  = field_step(sc_q, 7'd60, bus.set_inc);
                    pre_d = '0;
                end
                2'd2:    mn_d = field_step(mn_q, 7'd60, bus.set_inc);
                2'd3:    hr_d = field_step(hr_q, 7'd24, bus.set_inc);
                default: ;
            endcase
        end else if (bus.cnt_en) begin
            if (pre_last) begin
                pre_d = '0;
                hr_d  = hr_t;
                mn_d  = mn_t;
                sc_d  = sc_t;
                if (day_roll) begin
                    day_tick_d = 1'b1;
                    day_d      = day_q + DAY_W'(1);
                end
`ifdef BCD_CLOCK_ALARM_EN
                alarm_hit_d = bus.alarm_en && ({hr_t, mn_t, sc_t} == {alarm_q, 8'h00});
`endif
            end else begin
                pre_d = pre_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hr_q       <= 8'h00;
            mn_q       <= 8'h00;
            sc_q       <= 8'h00;
            pre_q      <= '0;
            day_q      <= '0;
            day_tick_q <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            hr_q       <= hr_d;
            mn_q       <= mn_d;
            sc_q       <= sc_d;
            pre_q      <= pre_d;
            day_q      <= day_d;
            day_tick_q <= day_tick_d;
            load_err_q <= load_err_d;
        end
    end

`ifdef BCD_CLOCK_ALARM_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            alarm_q     <= 16'h0000;
            alarm_hit_q <= 1'b0;
        end else begin
            if (bus.alarm_wr) alarm_q <= bus.alarm_time;
            alarm_hit_q <= alarm_hit_d;
        end
    end
    assign bus.alarm_hit = alarm_hit_q;
`endif

    // 12 h view: 00 shows as 12 AM, 12 stays 12 PM, 13..23 fold down by 12.
    always_comb begin
        hr_bin  = bcd2bin(hr_q);
        disp_hr = hr_q;
        pm_o    = 1'b0;
        if (bus.mode_12h) begin
            if (hr_bin == 7'd0) begin
                disp_hr = 8'h12;
            end else if (hr_bin == 7'd12) begin
                pm_o = 1'b1;
            end else if (hr_bin > 7'd12) begin
                disp_hr = bin2bcd(hr_bin - 7'd12);
                pm_o    = 1'b1;
            end
        end
    end

    assign bus.bcd_H1   = disp_hr[7:4];
    assign bus.bcd_H2   = disp_hr[3:0];
    assign bus.bcd_M1   = mn_q[7:4];
    assign bus.bcd_M2   = mn_q[3:0];
    assign bus.bcd_S1   = sc_q[7:4];
    assign bus.bcd_S2   = sc_q[3:0];
    assign bus.pm       = pm_o;
    assign bus.day_tick = day_tick_q;
    assign bus.day_cnt  = day_q;
    assign bus.load_err = load_err_q;
endmodule
